// File: rtl/nco_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : nco_pkg                                                          |
// | Shared channel count, tag FIFO depth, angle width and NCO result layout.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package nco_pkg;

   localparam int NCH       = 4;
   localparam int CH_W      = $clog2(NCH);
   localparam int TAG_DEPTH = 16;
   localparam int ANGLE_W   = 32;

   typedef logic [CH_W-1:0] chan_t;

   typedef struct packed {
      logic [15:0] im;
      logic [15:0] re;
   } nco_iq_t;

endpackage
`default_nettype wire

// File: rtl/nco_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nco_tag_fifo                                                      |
// | In-order channel-tag FIFO; push and pop may coincide even when full/empty. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module nco_tag_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [W-1:0]     push_dat,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_cnt;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (r_cnt == '0);
   assign w_full    = (r_cnt == CNT_W'(DEPTH));
   assign w_do_pop  = pop & !empty;
   assign w_do_push = push & (!w_full | w_do_pop);
   assign head      = r_mem[r_rd];
   assign count     = r_cnt;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= push_dat;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= f_next(r_wr);
         if (w_do_pop)  r_rd <= f_next(r_rd);
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/nco_chan_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nco_chan_sched                                                    |
// | Round-robin time-sharing of one NCO pipeline between NCH phase channels.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module nco_chan_sched
   import nco_pkg::*;
#(
   parameter int DAT_W = $bits(nco_iq_t)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [31:0]        cfg_freq,
   input  logic [31:0]        cfg_phase,
   input  logic               cfg_sync,
   input  logic [NCH-1:0]     ch_en,
   output logic [31:0]        i_angle_dat,
   output logic               i_angle_req,
   input  logic               i_angle_ack,
   input  logic [DAT_W-1:0]   t_nco_dat,
   input  logic               t_nco_req,
   output logic               t_nco_ack,
   output logic [DAT_W-1:0]   o_dat,
   output logic [CH_W-1:0]    o_ch,
   output logic               o_req,
   input  logic               o_ack,
   output logic               err
);

   localparam int CNT_W = $clog2(TAG_DEPTH + 1);

   logic [ANGLE_W-1:0] r_acc   [NCH];
   logic [ANGLE_W-1:0] r_freq  [NCH];
   logic [ANGLE_W-1:0] r_phase [NCH];
   chan_t              r_ptr;
   chan_t              r_tag;
   logic               r_req;
   logic [ANGLE_W-1:0] r_dat;
   logic               r_err;

   chan_t              w_grant;
   logic               w_grant_vld;
   logic               w_slot_free;
   logic               w_load;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   chan_t              w_head;
   logic [CNT_W-1:0]   w_count;
   logic [CNT_W:0]     w_inflight;

   assign i_angle_req = r_req;
   assign i_angle_dat = r_dat;
   assign err         = r_err;

   // Descending scan so the lowest offset from the pointer wins.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = r_ptr;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (ch_en[r_ptr + chan_t'(k)]) begin
            w_grant_vld = 1'b1;
            w_grant     = r_ptr + chan_t'(k);
         end
      end
   end

   // A transferring slot tag moves into the FIFO, so slot + FIFO stays constant.
   assign w_inflight  = {1'b0, w_count} + (CNT_W + 1)'(r_req);
   assign w_slot_free = !r_req | i_angle_ack;
   assign w_load      = w_slot_free & w_grant_vld &
                        (w_inflight < (CNT_W + 1)'(TAG_DEPTH));
   assign w_push      = r_req & i_angle_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req <= 1'b0;
         r_dat <= '0;
         r_tag <= '0;
         r_ptr <= '0;
      end else if (w_load) begin
         r_req <= 1'b1;
         r_dat <= r_acc[w_grant] + r_phase[w_grant];
         r_tag <= w_grant;
         r_ptr <= w_grant + chan_t'(1);
      end else if (i_angle_ack) begin
         r_req <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NCH; c++) begin
            r_acc[c]   <= '0;
            r_freq[c]  <= '0;
            r_phase[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (cfg_we && (cfg_ch == chan_t'(c))) begin
               r_freq[c]  <= cfg_freq;
               r_phase[c] <= cfg_phase;
            end
            if (cfg_sync) begin
               r_acc[c] <= '0;
            end else if (w_load && (w_grant == chan_t'(c))) begin
               r_acc[c] <= r_acc[c] + r_freq[c];
            end
         end
      end
   end

   nco_tag_fifo #(
      .DEPTH    (TAG_DEPTH),
      .W        (CH_W),
      .CNT_W    (CNT_W)
   ) u_tag_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (w_push),
      .push_dat (r_tag),
      .pop      (w_pop),
      .head     (w_head),
      .empty    (w_empty),
      .count    (w_count)
   );

   assign o_dat     = t_nco_dat;
   assign o_ch      = w_head;
   assign o_req     = t_nco_req & !w_empty;
   assign t_nco_ack = o_ack & !w_empty;
   assign w_pop     = t_nco_req & t_nco_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (t_nco_req && w_empty) begin
         r_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nco_chan_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_nco_chan_sched                                                 |
// | Directed bench for nco_chan_sched with a queue-based NCO stand-in.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_nco_chan_sched;
   import nco_pkg::*;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           cfg_we;
   chan_t          cfg_ch;
   logic [31:0]    cfg_freq;
   logic [31:0]    cfg_phase;
   logic           cfg_sync;
   logic [NCH-1:0] ch_en;
   logic [31:0]    i_angle_dat;
   logic           i_angle_req;
   logic           i_angle_ack;
   logic [31:0]    t_nco_dat;
   logic           t_nco_req;
   logic           t_nco_ack;
   logic [31:0]    o_dat;
   chan_t          o_ch;
   logic           o_req;
   logic           o_ack;
   logic           err;

   logic           nco_en;
   logic           inj_req;
   logic           nco_req_m;
   logic [31:0]    nco_dat_m;

   int             n_pass  = 0;
   int             n_total = 0;

   logic [31:0]    nco_q       [$];
   logic [31:0]    ang_log     [$];
   logic [31:0]    out_dat_log [$];
   chan_t          out_ch_log  [$];
   logic           mon_push;
   logic           mon_pop;
   logic [31:0]    mon_ang;
   logic [31:0]    got;
   chan_t          gch;

   assign t_nco_req = nco_req_m | inj_req;
   assign t_nco_dat = nco_dat_m;

   always #5 clk = ~clk;

   nco_chan_sched dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_freq    (cfg_freq),
      .cfg_phase   (cfg_phase),
      .cfg_sync    (cfg_sync),
      .ch_en       (ch_en),
      .i_angle_dat (i_angle_dat),
      .i_angle_req (i_angle_req),
      .i_angle_ack (i_angle_ack),
      .t_nco_dat   (t_nco_dat),
      .t_nco_req   (t_nco_req),
      .t_nco_ack   (t_nco_ack),
      .o_dat       (o_dat),
      .o_ch        (o_ch),
      .o_req       (o_req),
      .o_ack       (o_ack),
      .err         (err)
   );

   // NCO stand-in: returns each accepted angle unchanged, in order, when enabled.
   always begin
      @(negedge clk);
      mon_push = reset_n && i_angle_req && i_angle_ack;
      mon_pop  = reset_n && t_nco_req && t_nco_ack;
      mon_ang  = i_angle_dat;
      if (mon_push) ang_log.push_back(mon_ang);
      if (mon_pop) begin
         out_dat_log.push_back(o_dat);
         out_ch_log.push_back(o_ch);
      end
      @(posedge clk);
      #1;
      if (!reset_n) begin
         nco_q.delete();
      end else begin
         if (mon_pop && nco_q.size() > 0) void'(nco_q.pop_front());
         if (mon_push) nco_q.push_back(mon_ang);
      end
      nco_req_m = nco_en && (nco_q.size() > 0);
      nco_dat_m = (nco_q.size() > 0) ? nco_q[0] : 32'h0;
   end

   task automatic clear_logs();
      ang_log.delete();
      out_dat_log.delete();
      out_ch_log.delete();
   endtask

   task automatic apply_reset();
      ch_en    = '0;
      cfg_we   = 1'b0;
      cfg_sync = 1'b0;
      inj_req  = 1'b0;
      reset_n  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_logs();
      reset_n = 1'b1;
   endtask

   task automatic cfg_write(input int ch, input logic [31:0] f, input logic [31:0] p);
      cfg_we    = 1'b1;
      cfg_ch    = chan_t'(ch);
      cfg_freq  = f;
      cfg_phase = p;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   // Keeps ch_en asserted for exactly n grant edges.
   task automatic run_loads(input logic [NCH-1:0] mask, input int n);
      ch_en = mask;
      repeat (n) @(posedge clk);
      #1;
      ch_en = '0;
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_total++;
      if ({i_angle_req, o_req, t_nco_ack, err} !== 4'b0000)
         $display("FAIL reset_idle: got %b expected 0000", {i_angle_req, o_req, t_nco_ack, err});
      else n_pass++;
      n_total++;
      if (i_angle_dat !== 32'h0)
         $display("FAIL reset_dat: got %h expected 00000000", i_angle_dat);
      else n_pass++;

      i_angle_ack = 1'b1; o_ack = 1'b1; nco_en = 1'b1;
      cfg_write(0, 32'h0000_0100, 32'h0);
      inj_req = 1'b1;
      @(posedge clk);
      #1;
      inj_req = 1'b0;
      ch_en = 4'b0001;
      repeat (5) @(posedge clk);
      #1;
      n_total++;
      if ({i_angle_req, err} !== 2'b11)
         $display("FAIL pre_reset_busy: got %b expected 11", {i_angle_req, err});
      else n_pass++;

      reset_n = 1'b0;
      #1;
      n_total++;
      if ({i_angle_req, o_req, t_nco_ack, err} !== 4'b0000)
         $display("FAIL async_reset: got %b expected 0000", {i_angle_req, o_req, t_nco_ack, err});
      else n_pass++;
      n_total++;
      if (i_angle_dat !== 32'h0)
         $display("FAIL async_reset_dat: got %h expected 00000000", i_angle_dat);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      clear_logs();
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if ({i_angle_req, i_angle_dat} !== {1'b1, 32'h0})
         $display("FAIL post_reset_first: got req=%b dat=%h expected req=1 dat=00000000",
                  i_angle_req, i_angle_dat);
      else n_pass++;
      ch_en = '0;
      drain(15);
      got = (ang_log.size() > 0) ? ang_log[0] : 'x;
      n_total++;
      if (got !== 32'h0)
         $display("FAIL post_reset_angle0: got %h expected 00000000", got);
      else n_pass++;
      n_total++;
      if (o_req !== 1'b0)
         $display("FAIL post_reset_drained: got o_req=%b expected 0", o_req);
      else n_pass++;
   endtask

   task automatic test_single();
      apply_reset();
      i_angle_ack = 1'b1; o_ack = 1'b1; nco_en = 1'b1;
      cfg_write(0, 32'h0100_0000, 32'h0);
      ch_en = 4'b0001;
      @(posedge clk);
      #1;
      n_total++;
      if ({i_angle_req, i_angle_dat} !== {1'b1, 32'h0})
         $display("FAIL single_latency: got req=%b dat=%h expected req=1 dat=00000000",
                  i_angle_req, i_angle_dat);
      else n_pass++;
      repeat (5) @(posedge clk);
      #1;
      ch_en = '0;
      drain(15);
      n_total++;
      if (ang_log.size() != 6 || out_dat_log.size() != 6)
         $display("FAIL single_count: got %0d angles %0d results expected 6 6",
                  ang_log.size(), out_dat_log.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         got = (i < ang_log.size()) ? ang_log[i] : 'x;
         n_total++;
         if (got !== 32'(i) << 24)
            $display("FAIL single_angle[%0d]: got %h expected %h", i, got, 32'(i) << 24);
         else n_pass++;
         got = (i < out_dat_log.size()) ? out_dat_log[i] : 'x;
         gch = (i < out_ch_log.size()) ? out_ch_log[i] : 'x;
         n_total++;
         if ({gch, got} !== {chan_t'(0), 32'(i) << 24})
            $display("FAIL single_result[%0d]: got ch=%0d dat=%h expected ch=0 dat=%h",
                     i, gch, got, 32'(i) << 24);
         else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] ea [6];
      chan_t       ec [6];
      ea = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h20, 32'h40};
      ec = '{chan_t'(0), chan_t'(1), chan_t'(3), chan_t'(0), chan_t'(1), chan_t'(3)};
      apply_reset();
      i_angle_ack = 1'b1; o_ack = 1'b1; nco_en = 1'b1;
      cfg_write(0, 32'h10, 32'h0);
      cfg_write(1, 32'h20, 32'h0);
      cfg_write(3, 32'h40, 32'h0);
      run_loads(4'b1011, 6);
      drain(15);
      n_total++;
      if (ang_log.size() != 6 || out_ch_log.size() != 6)
         $display("FAIL rr_count: got %0d angles %0d results expected 6 6",
                  ang_log.size(), out_ch_log.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         got = (i < ang_log.size()) ? ang_log[i] : 'x;
         n_total++;
         if (got !== ea[i])
            $display("FAIL rr_angle[%0d]: got %h expected %h", i, got, ea[i]);
         else n_pass++;
         got = (i < out_dat_log.size()) ? out_dat_log[i] : 'x;
         gch = (i < out_ch_log.size()) ? out_ch_log[i] : 'x;
         n_total++;
         if ({gch, got} !== {ec[i], ea[i]})
            $display("FAIL rr_result[%0d]: got ch=%0d dat=%h expected ch=%0d dat=%h",
                     i, gch, got, ec[i], ea[i]);
         else n_pass++;
      end
   endtask

   task automatic test_wrap_sync();
      logic [31:0] ew [4];
      logic [31:0] es [4];
      ew = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'hC000_0000};
      es = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000};
      apply_reset();
      i_angle_ack = 1'b1; o_ack = 1'b1; nco_en = 1'b1;
      cfg_write(1, 32'hC000_0000, 32'h8000_0000);
      run_loads(4'b0010, 4);
      drain(12);
      for (int i = 0; i < 4; i++) begin
         got = (i < ang_log.size()) ? ang_log[i] : 'x;
         gch = (i < out_ch_log.size()) ? out_ch_log[i] : 'x;
         n_total++;
         if ({gch, got} !== {chan_t'(1), ew[i]})
            $display("FAIL wrap_angle[%0d]: got ch=%0d angle=%h expected ch=1 angle=%h",
                     i, gch, got, ew[i]);
         else n_pass++;
      end

      apply_reset();
      cfg_write(1, 32'hC000_0000, 32'h8000_0000);
      run_loads(4'b0010, 3);
      cfg_sync = 1'b1;
      @(posedge clk);
      #1;
      cfg_sync = 1'b0;
      run_loads(4'b0010, 1);
      drain(12);
      n_total++;
      if (ang_log.size() != 4)
         $display("FAIL sync_count: got %0d expected 4", ang_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         got = (i < ang_log.size()) ? ang_log[i] : 'x;
         n_total++;
         if (got !== es[i])
            $display("FAIL sync_angle[%0d]: got %h expected %h", i, got, es[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_pressure();
      int n;
      apply_reset();
      i_angle_ack = 1'b1; o_ack = 1'b0; nco_en = 1'b0;
      cfg_write(2, 32'h0000_1000, 32'h0000_0005);
      ch_en = 4'b0100;
      repeat (30) @(posedge clk);
      #1;
      n_total++;
      if (ang_log.size() != TAG_DEPTH)
         $display("FAIL bp_stall_count: got %0d expected %0d", ang_log.size(), TAG_DEPTH);
      else n_pass++;
      n_total++;
      if ({i_angle_req, o_req} !== 2'b00)
         $display("FAIL bp_stall_req: got %b expected 00", {i_angle_req, o_req});
      else n_pass++;

      nco_en = 1'b1; o_ack = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      ch_en = '0;
      drain(30);
      n = ang_log.size();
      n_total++;
      if (n <= TAG_DEPTH || out_ch_log.size() != n)
         $display("FAIL bp_resume_count: got %0d angles %0d results expected >%0d and equal",
                  n, out_ch_log.size(), TAG_DEPTH);
      else n_pass++;
      for (int i = 0; i < n; i++) begin
         n_total++;
         if (ang_log[i] !== 32'(i) * 32'h1000 + 32'h5)
            $display("FAIL bp_angle[%0d]: got %h expected %h", i, ang_log[i],
                     32'(i) * 32'h1000 + 32'h5);
         else n_pass++;
         got = (i < out_dat_log.size()) ? out_dat_log[i] : 'x;
         gch = (i < out_ch_log.size()) ? out_ch_log[i] : 'x;
         n_total++;
         if ({gch, got} !== {chan_t'(2), 32'(i) * 32'h1000 + 32'h5})
            $display("FAIL bp_result[%0d]: got ch=%0d dat=%h expected ch=2 dat=%h",
                     i, gch, got, 32'(i) * 32'h1000 + 32'h5);
         else n_pass++;
      end
   endtask

   task automatic test_err();
      apply_reset();
      i_angle_ack = 1'b1; o_ack = 1'b1; nco_en = 1'b1;
      n_total++;
      if (err !== 1'b0)
         $display("FAIL err_clear: got %b expected 0", err);
      else n_pass++;
      inj_req = 1'b1;
      #1;
      n_total++;
      if ({o_req, t_nco_ack} !== 2'b00)
         $display("FAIL err_empty_gate: got %b expected 00", {o_req, t_nco_ack});
      else n_pass++;
      @(posedge clk);
      #1;
      inj_req = 1'b0;
      n_total++;
      if (err !== 1'b1)
         $display("FAIL err_set: got %b expected 1", err);
      else n_pass++;
      cfg_write(0, 32'h1, 32'h0);
      run_loads(4'b0001, 5);
      drain(12);
      n_total++;
      if ({err, 3'(out_ch_log.size())} !== {1'b1, 3'd5})
         $display("FAIL err_sticky: got err=%b results=%0d expected err=1 results=5",
                  err, out_ch_log.size());
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (err !== 1'b0)
         $display("FAIL err_reset: got %b expected 0", err);
      else n_pass++;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      cfg_we      = 1'b0;
      cfg_ch      = '0;
      cfg_freq    = '0;
      cfg_phase   = '0;
      cfg_sync    = 1'b0;
      ch_en       = '0;
      i_angle_ack = 1'b0;
      o_ack       = 1'b0;
      nco_en      = 1'b0;
      inj_req     = 1'b0;
      nco_req_m   = 1'b0;
      nco_dat_m   = '0;

      test_reset();
      test_single();
      test_round_robin();
      test_wrap_sync();
      test_back_pressure();
      test_err();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nco_chan_sched.md
Name: nco_chan_sched

Overview:
Time-shares one drom_nco pipeline between NCH independent phase-accumulator channels. Each enabled channel gets a programmable frequency word and phase offset. Channels are granted round-robin; each granted channel's angle is pushed into the NCO angle target port through a registered req/ack slot. A channel-tag FIFO tracks in-order NCO results so each result leaves with its channel number.

Parameters:
NCH, 4, number of channels (power of 2, 2..16)
CH_W, log2(NCH), channel tag width (derived)
TAG_DEPTH, 16, max angles in flight (slot + NCO + results awaiting o_ack); must be >= 11
DAT_W, 32, NCO result width ({im[15:0], re[15:0]})

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  write cfg_freq/cfg_phase to channel cfg_ch
cfg_ch  in  CH_W  configured channel
cfg_freq  in  32  frequency (phase increment) word
cfg_phase  in  32  phase offset word
cfg_sync  in  1  clear all channel accumulators
ch_en  in  NCH  per-channel enable
i_angle_dat  out  32  angle to NCO
i_angle_req  out  1  angle valid
i_angle_ack  in  1  NCO accepts angle
t_nco_dat  in  DAT_W  NCO result
t_nco_req  in  1  NCO result valid
t_nco_ack  out  1  result accepted
o_dat  out  DAT_W  result to consumer
o_ch  out  CH_W  channel of o_dat
o_req  out  1  result valid
o_ack  in  1  consumer accepts
err  out  1  sticky protocol error

Behaviour:
- Reset (async, reset_n low):
  - Cleared to 0: i_angle_req, i_angle_dat, err, every acc[c], freq[c], phase[c], RR pointer.
  - Tag FIFO and slot empty.
  - Resulting outputs: o_req=0, t_nco_ack=0.
- Handshake rule: a transfer occurs when req & ack in the same cycle. req and dat are held stable until that transfer.
- Credit: inflight = tag FIFO count + slot occupied (i_angle_req).
- Slot load conditions, evaluated each cycle; all must hold:
  - slot is free: !i_angle_req | i_angle_ack
  - some ch_en bit is set
  - credit available: inflight_after_ack < TAG_DEPTH
- On slot load at channel g (g = first enabled channel searched from ptr upward, mod NCH):
  - i_angle_dat <= acc[g] + phase[g] (mod 2^32)
  - slot tag <= g
  - i_angle_req <= 1
  - acc[g] <= acc[g] + freq[g] (mod 2^32, wraps silently)
  - ptr <= (g+1) mod NCH
- No slot load and slot freed by ack: i_angle_req <= 0.
- Issue rate: one angle per cycle sustained while i_angle_ack=1 and credit is available. Latency from ch_en rising to i_angle_req is 1 cycle.
- Angle transfer: slot tag is pushed into the tag FIFO. Load and push may coincide.
- Return path (combinational, no added latency):
  - o_dat = t_nco_dat
  - o_ch = FIFO head
  - o_req = t_nco_req & !empty
  - t_nco_ack = o_ack & !empty
  - Pop on t_nco_req & t_nco_ack.
- err: set when t_nco_req=1 with FIFO empty; sticky until reset.
- Config write:
  - cfg_we updates freq/phase of cfg_ch at the clock edge.
  - A load of the same channel in that cycle uses the old values.
  - A channel with cfg_we pending at a clock edge is not affected in its accumulator.
- cfg_sync: every acc[c] <= 0. It overrides a same-cycle accumulator update. The slot content, FIFO and ptr are unaffected.
- ch_en changes take effect at the next grant. A slot already loaded is still delivered.
- NCH=1 is not supported.

Decomposition:
- Shared package nco_pkg:
  - NCH, CH_W, TAG_DEPTH, ANGLE_W=32
  - typedef chan_t (CH_W bits)
  - typedef nco_iq_t ({im, re} 16+16)
- Sub-module nco_tag_fifo (depth TAG_DEPTH, width CH_W):
  - synchronous push/pop
  - simultaneous push+pop allowed when full or empty
  - count output used for credit
- RR arbiter and accumulators stay in nco_chan_sched.

Test Plan:
- Reset, assert mid-traffic -> i_angle_req, o_req, t_nco_ack, err drop to 0 immediately; FIFO empty; after release, first angle for ch0 is 0.
- ch_en=0001, freq[0]=0x0100_0000, phase 0, all acks 1 -> angles 0x00000000, 0x01000000, 0x02000000, ...; every result o_ch=0.
- ch_en=1011, freq=0x10,0x20,-,0x40 -> grant order 0,1,3,0,1,3; angles 0,0,0,0x10,0x20,0x40; o_ch returns 0,1,3,0,1,3 in order.
- freq[1]=0xC000_0000, phase[1]=0x8000_0000, ch_en=0010 -> angles 0x80000000, 0x40000000, 0x00000000, 0xC0000000 (wrap); cfg_sync after 3rd -> next angle 0x80000000.
- Behavioural NCO acking angles but never returning results -> exactly 16 angle transfers, then i_angle_req=0. Then o_ack=1 with results flowing -> no tag lost; the accumulator sequence continues without gaps.
- t_nco_req pulse with FIFO empty -> err=1 next cycle, stays 1 during further traffic until reset_n low.
